// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper: state encoding and
// the built-in 3-input function.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // s = a&~c | a&~b&c with a = MSB -> minterms 4, 5, 6
  localparam logic [7:0] DEFAULT_MASK_N3 = 8'h70;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Control/result bundle of the truth-table sweeper; the master side starts
// sweeps and steps them, the slave side is the sweeper itself.
interface truth_table_sweeper_if #(
  parameter int N = 3
);
  logic              start;
  logic              mode;
  logic              step;
  logic              use_default;
  logic [2**N-1:0]   tt_mask;
  logic [N-1:0]      in_vec;
  logic              s;
  logic              valid;
  logic              busy;
  logic              done;
  logic [2**N-1:0]   table_out;
  logic [N:0]        ones_cnt;

  modport master (
    output start, mode, step, use_default, tt_mask,
    input  in_vec, s, valid, busy, done, table_out, ones_cnt
  );

  modport slave (
    input  start, mode, step, use_default, tt_mask,
    output in_vec, s, valid, busy, done, table_out, ones_cnt
  );
endinterface

// File: rtl/truth_table_sweeper_sweep_counter.sv
// N-bit sweep index with synchronous clear and enable; saturates at the last
// index instead of wrapping.
module truth_table_sweeper_sweep_counter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] idx_o,
  output logic         last_o
);
  logic [N-1:0] idx_q, idx_d;

  assign last_o = &idx_q;
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr_i)
      idx_d = '0;
    else if (en_i && !last_o)
      idx_d = idx_q + N'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      idx_q <= '0;
    else
      idx_q <= idx_d;
  end
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2**N input combinations of a programmable truth table, reporting
// each evaluation and accumulating the captured table and minterm count.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int              N            = 3,
  parameter logic [2**N-1:0] DEFAULT_MASK = (2**N)'(DEFAULT_MASK_N3)
) (
  input logic                  clk,
  input logic                  reset,
  truth_table_sweeper_if.slave sw
);
  // state   | meaning
  // IDLE    | waiting for first start
  // RUN     | evaluating combinations (free-running or per step)
  // DONE    | sweep complete, results held until next start
  localparam int W = 2**N;

  state_e         state_q, state_d;
  logic [W-1:0]   mask_q, mask_d, table_q, table_d;
  logic [N-1:0]   in_vec_q, in_vec_d, idx;
  logic [N:0]     ones_q, ones_d;
  logic           mode_q, mode_d, s_q, s_d, valid_q, valid_d, done_q, done_d;
  logic           launch, advance, last, bit_now;

  assign launch  = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && sw.start;
  assign advance = (state_q == ST_RUN) && (!mode_q || sw.step);
  assign bit_now = mask_q[idx];

  truth_table_sweeper_sweep_counter #(.N(N)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (launch),
    .en_i   (advance),
    .idx_o  (idx),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (sw.start) state_d = ST_RUN;
      ST_RUN:           if (advance && last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Launch takes priority, so a step coinciding with start is dropped.
  always_comb begin
    mask_d   = mask_q;
    mode_d   = mode_q;
    table_d  = table_q;
    ones_d   = ones_q;
    in_vec_d = in_vec_q;
    s_d      = s_q;
    done_d   = done_q;
    valid_d  = 1'b0;
    if (launch) begin
      mask_d  = sw.use_default ? DEFAULT_MASK : sw.tt_mask;
      mode_d  = sw.mode;
      table_d = '0;
      ones_d  = '0;
      done_d  = 1'b0;
    end else if (advance) begin
      in_vec_d     = idx;
      s_d          = bit_now;
      valid_d      = 1'b1;
      table_d[idx] = bit_now;
      ones_d       = ones_q + (N+1)'(bit_now);
      if (last)
        done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q   <= '0;
      mode_q   <= 1'b0;
      table_q  <= '0;
      ones_q   <= '0;
      in_vec_q <= '0;
      s_q      <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      table_q  <= table_d;
      ones_q   <= ones_d;
      in_vec_q <= in_vec_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign sw.in_vec    = in_vec_q;
  assign sw.s         = s_q;
  assign sw.valid     = valid_q;
  assign sw.busy      = (state_q == ST_RUN);
  assign sw.done      = done_q;
  assign sw.table_out = table_q;
  assign sw.ones_cnt  = ones_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper (N=3): sweep-position model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_truth_table_sweeper;
  localparam int N = 3;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N(N)) bus();
  truth_table_sweeper #(.N(N)) dut (.clk(clk), .reset(reset), .sw(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sweep is described by how many combinations have been evaluated.
  bit         m_run, m_valid, m_done, m_mode, m_last_s;
  int         m_pos, m_last_in;
  logic [7:0] m_mask;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_valid = 0; m_done = 0; m_mode = 0; m_last_s = 0;
      m_pos = 0; m_last_in = 0; m_mask = 8'h00;
    end else begin
      m_valid = 0;
      if (!m_run && bus.start) begin
        m_mask = bus.use_default ? 8'h70 : bus.tt_mask;
        m_mode = bus.mode;
        m_pos  = 0;
        m_run  = 1;
        m_done = 0;
      end else if (m_run && (!m_mode || bus.step)) begin
        m_last_in = m_pos;
        m_last_s  = m_mask[m_pos];
        m_pos++;
        m_valid = 1;
        if (m_pos == W) begin
          m_run  = 0;
          m_done = 1;
        end
      end
    end
  end

  function automatic logic [7:0] exp_table();
    return m_mask & 8'((1 << m_pos) - 1);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("valid",     32'(bus.valid),     32'(m_valid));
      check("busy",      32'(bus.busy),      32'(m_run));
      check("done",      32'(bus.done),      32'(m_done));
      check("table_out", 32'(bus.table_out), 32'(exp_table()));
      check("ones_cnt",  32'(bus.ones_cnt),  32'($countones(exp_table())));
      check("in_vec",    32'(bus.in_vec),    32'(m_last_in));
      check("s",         32'(bus.s),         32'(m_last_s));
    end
  end

  int cap_in[$];
  bit cap_s[$];
  always @(negedge clk) begin
    if (!reset && bus.valid) begin
      cap_in.push_back(int'(bus.in_vec));
      cap_s.push_back(bus.s);
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(input bit ud, input bit m, input logic [7:0] mask, input bit stp);
    cap_in.delete();
    cap_s.delete();
    bus.start = 1'b1; bus.use_default = ud; bus.mode = m; bus.tt_mask = mask; bus.step = stp;
    nxt();
    bus.start = 1'b0; bus.step = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!bus.done && c < 40) begin
      nxt();
      c++;
    end
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    nxt();
    bus.step = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},  32'(bus.valid),     0);
    check({tag, "_busy"},   32'(bus.busy),      0);
    check({tag, "_done"},   32'(bus.done),      0);
    check({tag, "_table"},  32'(bus.table_out), 0);
    check({tag, "_ones"},   32'(bus.ones_cnt),  0);
    check({tag, "_in_vec"}, 32'(bus.in_vec),    0);
    check({tag, "_s"},      32'(bus.s),         0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit exp_s_def[8] = '{0, 0, 0, 0, 1, 1, 1, 0};

  initial begin
    int c;
    bus.start = 0; bus.mode = 0; bus.step = 0; bus.use_default = 0; bus.tt_mask = 8'h00;
    reset = 1'b1;
    nxt(); nxt();
    check_all_zero("reset");
    reset = 1'b0;
    nxt();

    // Single-step mode; step coinciding with start must be ignored
    do_start(1'b0, 1'b1, 8'h0F, 1'b1);
    nxt(); nxt();
    check("start_step_ignored", cap_in.size(), 0);
    for (int i = 0; i < 3; i++) begin
      pulse_step();
      nxt(); nxt();
    end
    check("step_count", cap_in.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < cap_in.size()) begin
        check("step_in_vec", cap_in[i], i);
        check("step_s", 32'(cap_s[i]), 1);
      end
    end
    check("step_busy", 32'(bus.busy), 1);
    check("step_done", 32'(bus.done), 0);

    // Asynchronous reset mid-sweep, checked between clock edges
    pulse_step();
    check("pre_reset_in_vec", 32'(bus.in_vec), 3);
    #2 reset = 1'b1;
    #1 check_all_zero("async");
    nxt();
    reset = 1'b0;
    nxt();

    // Default function, free-running
    do_start(1'b1, 1'b0, 8'h00, 1'b0);
    wait_done(c);
    check("default_latency", c, 8);
    check("default_count", cap_in.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_in.size()) begin
        check("default_in_vec", cap_in[i], i);
        check("default_s", 32'(cap_s[i]), 32'(exp_s_def[i]));
      end
    end
    check("default_table", 32'(bus.table_out), 32'h70);
    check("default_ones", 32'(bus.ones_cnt), 3);

    // User mask; input changes during RUN have no effect
    do_start(1'b0, 1'b0, 8'hA5, 1'b0);
    nxt(); nxt(); nxt();
    bus.tt_mask = 8'hFF; bus.use_default = 1'b1; bus.mode = 1'b1;
    wait_done(c);
    check("a5_done", 32'(bus.done), 1);
    check("a5_table", 32'(bus.table_out), 32'hA5);
    check("a5_ones", 32'(bus.ones_cnt), 4);
    bus.tt_mask = 8'h00; bus.use_default = 1'b0; bus.mode = 1'b0;

    // start during RUN is ignored
    do_start(1'b1, 1'b0, 8'h00, 1'b0);
    nxt(); nxt(); nxt(); nxt(); nxt();
    bus.start = 1'b1; bus.tt_mask = 8'hFF; bus.use_default = 1'b0;
    nxt();
    bus.start = 1'b0;
    wait_done(c);
    check("restart_ignored_latency", c, 2);
    check("restart_ignored_count", cap_in.size(), 8);
    check("restart_ignored_table", 32'(bus.table_out), 32'h70);
    nxt(); nxt();

    // start from DONE clears results; all-zero mask
    do_start(1'b0, 1'b0, 8'h00, 1'b0);
    check("redo_table_clear", 32'(bus.table_out), 0);
    check("redo_ones_clear", 32'(bus.ones_cnt), 0);
    check("redo_busy", 32'(bus.busy), 1);
    check("redo_done", 32'(bus.done), 0);
    wait_done(c);
    check("zero_latency", c, 8);
    check("zero_table", 32'(bus.table_out), 0);
    check("zero_ones", 32'(bus.ones_cnt), 0);

    // All-ones mask: counter reaches 8 without overflow
    do_start(1'b0, 1'b0, 8'hFF, 1'b0);
    wait_done(c);
    check("ff_latency", c, 8);
    check("ff_table", 32'(bus.table_out), 32'hFF);
    check("ff_ones", 32'(bus.ones_cnt), 8);
    nxt(); nxt(); nxt();
    check("ff_hold_ones", 32'(bus.ones_cnt), 8);
    check("ff_hold_in_vec", 32'(bus.in_vec), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
